// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch with one outstanding imem request
// and a DEPTH-entry prefetch buffer toward ID.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   op_inst_req,
   output logic [XLEN-1:0]        op_inst_addr,
   input  logic                   ip_inst_valid,
   input  logic [31:0]            ip_inst_from_imem,
   input  logic                   ip_redirect,
   input  logic [XLEN-1:0]        ip_redirect_pc,
   output logic                   op_if_valid,
   output logic [XLEN-1:0]        op_if_pc,
   output logic [31:0]            op_if_inst,
   input  logic                   ip_id_ready,
   output logic [$clog2(DEPTH):0] op_buf_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int UW = CW + 1;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            outstanding;
   logic            discard;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic            empty;
   logic            resp_acc;
   logic            push;
   logic            pop;
   logic [UW-1:0]   credit;

   assign empty    = (count == '0);
   assign resp_acc = outstanding && ip_inst_valid;
   assign push     = resp_acc && !discard && !ip_redirect;

   assign op_if_valid = !empty && !ip_redirect;
   assign pop         = op_if_valid && ip_id_ready;

   // An in-flight request already owns a slot; a pop frees one this cycle.
   assign credit = UW'(count) + UW'(outstanding) - UW'(pop);

   assign op_inst_req = reset && !ip_redirect
                     && (!outstanding || ip_inst_valid)
                     && (credit < UW'(DEPTH));

   assign op_inst_addr = pc;
   assign op_buf_count = count;
   assign op_if_pc     = empty ? '0 : pc_mem[rd_ptr];
   assign op_if_inst   = empty ? '0 : inst_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         req_pc      <= RESET_PC;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (ip_redirect) begin
         pc          <= ip_redirect_pc & ~XLEN'(3);
         outstanding <= outstanding && !ip_inst_valid;
         discard     <= outstanding && !ip_inst_valid;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         if (op_inst_req) begin
            pc     <= pc + XLEN'(4);
            req_pc <= pc;
         end
         if (op_inst_req) begin
            outstanding <= 1'b1;
         end else if (resp_acc) begin
            outstanding <= 1'b0;
         end
         if (resp_acc) begin
            discard <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc;
         inst_mem[wr_ptr] <= ip_inst_from_imem;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed steps driving an imem model; expected PCs
// are queued per step and popped at every ID handshake.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        op_inst_req;
   logic [31:0] op_inst_addr;
   logic        ip_inst_valid;
   logic [31:0] ip_inst_from_imem;
   logic        ip_redirect;
   logic [31:0] ip_redirect_pc;
   logic        op_if_valid;
   logic [31:0] op_if_pc;
   logic [31:0] op_if_inst;
   logic        ip_id_ready;
   logic [2:0]  op_buf_count;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN(32),
      .RESET_PC(32'h0),
      .DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .op_inst_req(op_inst_req),
      .op_inst_addr(op_inst_addr),
      .ip_inst_valid(ip_inst_valid),
      .ip_inst_from_imem(ip_inst_from_imem),
      .ip_redirect(ip_redirect),
      .ip_redirect_pc(ip_redirect_pc),
      .op_if_valid(op_if_valid),
      .op_if_pc(op_if_pc),
      .op_if_inst(op_if_inst),
      .ip_id_ready(ip_id_ready),
      .op_buf_count(op_buf_count)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        mq[$];
   logic [31:0] exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cycle = 0;
   int          lat = 1;
   logic        n_reset = 1'b0;
   logic        n_rdy = 1'b0;
   logic        n_redir = 1'b0;
   logic        n_stray = 1'b0;
   logic [31:0] n_rpc = '0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive next inputs at negedge, settle, log requests, score pops.
   task automatic cyc();
      logic [31:0] e;
      @(negedge clk);
      cycle++;
      reset          = n_reset;
      ip_id_ready    = n_rdy;
      ip_redirect    = n_redir;
      ip_redirect_pc = n_rpc;
      ip_inst_valid     = 1'b0;
      ip_inst_from_imem = '0;
      if (!n_reset) begin
         mq.delete();
      end else if (mq.size() > 0 && mq[0].due <= cycle) begin
         ip_inst_valid     = 1'b1;
         ip_inst_from_imem = word(mq[0].addr);
         void'(mq.pop_front());
      end
      if (n_stray) begin
         ip_inst_valid     = 1'b1;
         ip_inst_from_imem = 32'hDEAD_BEEF;
         n_stray = 1'b0;
      end
      #1;
      if (op_inst_req) begin
         mq.push_back('{op_inst_addr, cycle + lat});
      end
      if (op_if_valid && ip_id_ready) begin
         chk("sb_pop", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", op_if_pc, e);
            chk("sb_inst", op_if_inst, word(e));
         end
      end
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      cyc();
      n_reset = 1'b1;
   endtask

   initial begin
      int nreq;
      reset = 1'b0;
      ip_inst_valid = 1'b0;
      ip_inst_from_imem = '0;
      ip_redirect = 1'b0;
      ip_redirect_pc = '0;
      ip_id_ready = 1'b0;

      cyc();
      cyc();
      chk("rst_req", 32'(op_inst_req), 0);
      chk("rst_valid", 32'(op_if_valid), 0);
      chk("rst_count", 32'(op_buf_count), 0);
      chk("rst_if_pc", op_if_pc, 0);
      chk("rst_if_inst", op_if_inst, 0);
      chk("rst_addr", op_inst_addr, 0);

      // streaming with 1-cycle imem
      n_reset = 1'b1;
      n_rdy = 1'b1;
      lat = 1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t1_req", 32'(op_inst_req), 1);
         chk("t1_addr", op_inst_addr, 32'(i * 4));
         if (i < 2) chk("t1_novalid", 32'(op_if_valid), 0);
         else chk("t1_if_pc", op_if_pc, 32'((i - 2) * 4));
      end
      chk("t1_sb", exp_q.size(), 0);

      // fill to DEPTH with ID stalled
      n_rdy = 1'b0;
      do_reset();
      nreq = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (op_inst_req) nreq++;
      end
      chk("t2_nreq", nreq, 4);
      chk("t2_full_req", 32'(op_inst_req), 0);
      chk("t2_full_count", 32'(op_buf_count), 4);
      exp_q.push_back(32'h0);
      n_rdy = 1'b1;
      cyc();
      chk("t2_pop_req", 32'(op_inst_req), 1);
      chk("t2_pop_addr", op_inst_addr, 32'h10);
      n_rdy = 1'b0;
      cyc();
      chk("t2_count", 32'(op_buf_count), 3);
      chk("t2_sb", exp_q.size(), 0);

      // 3-cycle imem, redirect while 0x8 is in flight
      lat = 3;
      n_rdy = 1'b1;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h100);
      cyc();
      chk("t3_req0", 32'(op_inst_req), 1);
      repeat (2) cyc();
      chk("t3_wait", 32'(op_inst_req), 0);
      cyc();
      chk("t3_addr4", op_inst_addr, 32'h4);
      repeat (3) cyc();
      chk("t3_req8", 32'(op_inst_req), 1);
      chk("t3_addr8", op_inst_addr, 32'h8);
      n_redir = 1'b1;
      n_rpc = 32'h100;
      cyc();
      chk("t3_redir_valid", 32'(op_if_valid), 0);
      chk("t3_redir_req", 32'(op_inst_req), 0);
      n_redir = 1'b0;
      cyc();
      chk("t3_tgt_addr", op_inst_addr, 32'h100);
      chk("t3_flush_count", 32'(op_buf_count), 0);
      chk("t3_hold_req", 32'(op_inst_req), 0);
      cyc();
      chk("t3_tgt_req", 32'(op_inst_req), 1);
      cyc();
      chk("t3_drop_count", 32'(op_buf_count), 0);
      repeat (3) cyc();
      chk("t3_first_pc", op_if_pc, 32'h100);
      chk("t3_sb", exp_q.size(), 0);

      // redirect coincident with a response and ID ready
      lat = 1;
      n_rdy = 1'b1;
      do_reset();
      exp_q.push_back(32'h200);
      repeat (2) cyc();
      n_redir = 1'b1;
      n_rpc = 32'h200;
      cyc();
      chk("t4_resp_seen", 32'(ip_inst_valid), 1);
      chk("t4_valid", 32'(op_if_valid), 0);
      chk("t4_req", 32'(op_inst_req), 0);
      n_redir = 1'b0;
      cyc();
      chk("t4_count", 32'(op_buf_count), 0);
      chk("t4_req_tgt", 32'(op_inst_req), 1);
      chk("t4_addr_tgt", op_inst_addr, 32'h200);
      repeat (2) cyc();
      chk("t4_pc", op_if_pc, 32'h200);
      chk("t4_sb", exp_q.size(), 0);

      // back-to-back redirects, misaligned target, PC wrap
      do_reset();
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      n_redir = 1'b1;
      n_rpc = 32'h300;
      cyc();
      n_rpc = 32'hFFFF_FFFE;
      cyc();
      chk("t5_mid_addr", op_inst_addr, 32'h300);
      n_redir = 1'b0;
      cyc();
      chk("t5_req", 32'(op_inst_req), 1);
      chk("t5_addr", op_inst_addr, 32'hFFFF_FFFC);
      cyc();
      chk("t5_wrap_req", 32'(op_inst_req), 1);
      chk("t5_wrap_addr", op_inst_addr, 32'h0);
      repeat (2) cyc();
      chk("t5_sb", exp_q.size(), 0);

      // reset with entries buffered and a request in flight
      lat = 3;
      n_rdy = 1'b0;
      do_reset();
      repeat (8) cyc();
      chk("t6_pre_count", 32'(op_buf_count), 2);
      do_reset();
      chk("t6_rst_count", 32'(op_buf_count), 0);
      chk("t6_rst_req", 32'(op_inst_req), 0);
      chk("t6_rst_valid", 32'(op_if_valid), 0);
      n_stray = 1'b1;
      cyc();
      chk("t6_req", 32'(op_inst_req), 1);
      chk("t6_addr", op_inst_addr, 32'h0);
      cyc();
      chk("t6_stray_count", 32'(op_buf_count), 0);
      chk("t6_stray_valid", 32'(op_if_valid), 0);
      chk("t6_sb", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
